// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scanner for a common-anode 7-segment display.
// Holds a double-buffered display word, walks the digits one slot at a time and
// drives the matching active-low anode. The pending word moves to the active word
// only at the end of a frame, so a frame never mixes two display words.
// Optional feature macro: LEADING_ZERO_BLANK_EN (keeps the anodes of leading zero
// digits off for their whole slot; digit 0 is always shown).
module display_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    input  logic [4*NUM_DIGITS-1:0]                              data_in_i,
    input  logic                                                 load_i,
    output logic [3:0]                                           digit_nibble_o,
    output logic [NUM_DIGITS-1:0]                                anode_n_o,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx_o,
    output logic                                                 frame_done_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    // One extra bit so the blanking limit can never alias onto a wrapped value.
    localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W+1)'(BLANK_CYCLES);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;

    logic                    tick;
    logic                    last_digit;
    logic                    frame_end;
    logic                    commit;
    logic                    in_blank;
    logic [NUM_DIGITS-1:0]   leading;

    assign tick       = (cnt_q == CNT_LAST);
    assign last_digit = (idx_q == IDX_LAST);
    assign frame_end  = tick & last_digit;
    assign commit     = frame_end & pending_valid_q;
    assign in_blank   = ({1'b0, cnt_q} < BLANK_LIM);

    // Slot counter and digit index: advance the digit once per full slot.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end
    end

    // Double buffer: commit pending at frame end, then capture a new load.
    // Commit reads pending_q, so a load on the commit cycle becomes the next pending.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (commit) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end
        if (load_i) begin
            pending_d       = data_in_i;
            pending_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset drops any pending load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    // Leading-digit mask: digit k>0 is leading when digits k..top are all zero.
`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        leading  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (active_q[4*k +: 4] == 4'h0);
            leading[k] = zero_run;
        end
    end
`else
    // Every digit is lit in its slot; zeros are displayed.
    always_comb begin
        leading = '0;
    end
`endif

    // Nibble select from the active word for the digit in its slot.
    always_comb begin
        digit_nibble_o = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit_nibble_o = active_q[4*k +: 4];
            end
        end
    end

    // Anode enables: all off during the anti-ghost window or for a leading digit.
    always_comb begin
        anode_n_o = '1;
        if (!in_blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if ((idx_q == IDX_W'(k)) && !leading[k]) begin
                    anode_n_o[k] = 1'b0;
                end
            end
        end
    end

    // Index and frame-boundary pulse straight from registered state.
    always_comb begin
        digit_idx_o  = idx_q;
        frame_done_o = frame_end;
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed and randomized checks of display_scan_mux with
// NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1. The reference model tracks time as
// a cycle count since reset and derives slot/digit/frame position arithmetically.
module tb_display_scan_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        load_i = 1'b0;
    logic [15:0] data_in_i = 16'h0;
    logic [3:0]  digit_nibble_o;
    logic [3:0]  anode_n_o;
    logic [1:0]  digit_idx_o;
    logic        frame_done_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_t = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_pend   = 16'h0;
    bit          m_pv     = 1'b0;

    display_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .data_in_i      (data_in_i),
        .load_i         (load_i),
        .digit_nibble_o (digit_nibble_o),
        .anode_n_o      (anode_n_o),
        .digit_idx_o    (digit_idx_o),
        .frame_done_o   (frame_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int m_cnt();
        return m_t % RD;
    endfunction

    function automatic int m_idx();
        return (m_t / RD) % ND;
    endfunction

    function automatic logic m_fd();
        return (m_t % (RD * ND)) == (RD * ND - 1);
    endfunction

    function automatic logic [3:0] m_nibble();
        return 4'(m_active >> (4 * m_idx()));
    endfunction

    function automatic logic [3:0] m_anode();
        logic [3:0] a;
        a = 4'hF;
        if (m_cnt() >= BC) begin
            if (!(LZB && m_idx() > 0 && (m_active >> (4 * m_idx())) == 16'h0))
                a[m_idx()] = 1'b0;
        end
        return a;
    endfunction

    // One clock cycle: present load/data, advance model by the spec's rules.
    task automatic cyc(input logic ld, input logic [15:0] d);
        load_i    = ld;
        data_in_i = d;
        if (m_fd() && m_pv) begin
            m_active = m_pend;
            m_pv     = 1'b0;
        end
        if (ld) begin
            m_pend = d;
            m_pv   = 1'b1;
        end
        @(posedge clk);
        #1;
        m_t++;
        load_i = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_i  = 1'b1;
        load_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_i    = 1'b0;
        m_t      = 0;
        m_active = 16'h0;
        m_pend   = 16'h0;
        m_pv     = 1'b0;
    endtask

    // Advance until frame_done is high (without crossing it); bounded.
    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_done_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc(1'b0, 16'h0);
        end
    endtask

    task automatic test_reset();
        int first_fd;
        rst_i  = 1'b1;
        load_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (anode_n_o !== 4'b1111) begin bad++; $display("FAIL reset_anode: got %b want 1111", anode_n_o); end
        total++;
        if (digit_nibble_o !== 4'h0) begin bad++; $display("FAIL reset_nibble: got %h want 0", digit_nibble_o); end
        total++;
        if (digit_idx_o !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", digit_idx_o); end
        total++;
        if (frame_done_o !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", frame_done_o); end
        rst_i    = 1'b0;
        m_t      = 0;
        m_active = 16'h0;
        m_pend   = 16'h0;
        m_pv     = 1'b0;
        first_fd = -1;
        for (int i = 0; i < 20; i++) begin
            if (frame_done_o === 1'b1 && first_fd < 0) first_fd = i;
            cyc(1'b0, 16'h0);
        end
        total++;
        if (first_fd != 15) begin bad++; $display("FAIL reset_first_fd: got cycle %0d want 15", first_fd); end
    endtask

    task automatic test_scan_order();
        bit ok;
        logic [3:0] nib_tab [4];
        logic [3:0] ea;
        nib_tab = '{4'hF, 4'h3, 4'hA, 4'h1};
        cyc(1'b1, 16'h1A3F);
        wait_fd(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL scan_wait_fd: got timeout want frame_done"); end
        cyc(1'b0, 16'h0);
        for (int c = 0; c < 16; c++) begin
            ea = 4'hF;
            if (c % 4 != 0) ea[c / 4] = 1'b0;
            total++;
            if (digit_idx_o !== 2'(c / 4)) begin bad++; $display("FAIL scan_idx c=%0d: got %0d want %0d", c, digit_idx_o, c / 4); end
            total++;
            if (digit_nibble_o !== nib_tab[c / 4]) begin bad++; $display("FAIL scan_nibble c=%0d: got %h want %h", c, digit_nibble_o, nib_tab[c / 4]); end
            total++;
            if (anode_n_o !== ea) begin bad++; $display("FAIL scan_anode c=%0d: got %b want %b", c, anode_n_o, ea); end
            total++;
            if (frame_done_o !== (c == 15)) begin bad++; $display("FAIL scan_fd c=%0d: got %b want %b", c, frame_done_o, c == 15); end
            cyc(1'b0, 16'h0);
        end
    endtask

    task automatic test_no_tearing();
        bit ok;
        cyc(1'b1, 16'h5678);
        wait_fd(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL tear_wait_fd: got timeout want frame_done"); end
        cyc(1'b0, 16'h0);
        repeat (5) cyc(1'b0, 16'h0);
        total++;
        if (digit_idx_o !== 2'd1) begin bad++; $display("FAIL tear_load_idx: got %0d want 1", digit_idx_o); end
        cyc(1'b1, 16'h1234);
        for (int c = 6; c <= 21; c++) begin
            if (c == 9) begin
                total++;
                if (digit_nibble_o !== 4'h6) begin bad++; $display("FAIL tear_d2: got %h want 6", digit_nibble_o); end
            end
            if (c == 13) begin
                total++;
                if (digit_nibble_o !== 4'h5) begin bad++; $display("FAIL tear_d3: got %h want 5", digit_nibble_o); end
            end
            if (c == 17) begin
                total++;
                if (digit_nibble_o !== 4'h4) begin bad++; $display("FAIL tear_next_d0: got %h want 4", digit_nibble_o); end
            end
            if (c == 21) begin
                total++;
                if (digit_nibble_o !== 4'h3) begin bad++; $display("FAIL tear_next_d1: got %h want 3", digit_nibble_o); end
            end
            cyc(1'b0, 16'h0);
        end
    endtask

    task automatic test_last_wins();
        bit ok;
        wait_fd(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL lw_align: got timeout want frame_done"); end
        cyc(1'b0, 16'h0);
        cyc(1'b1, 16'hAAAA);
        cyc(1'b1, 16'hBBBB);
        wait_fd(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL lw_wait_fd: got timeout want frame_done"); end
        cyc(1'b1, 16'hCCCC);
        for (int c = 0; c < 16; c++) begin
            total++;
            if (digit_nibble_o !== 4'hB) begin bad++; $display("FAIL lw_bbbb c=%0d: got %h want b", c, digit_nibble_o); end
            cyc(1'b0, 16'h0);
        end
        for (int c = 0; c < 16; c++) begin
            total++;
            if (digit_nibble_o !== 4'hC) begin bad++; $display("FAIL lw_cccc c=%0d: got %h want c", c, digit_nibble_o); end
            cyc(1'b0, 16'h0);
        end
    endtask

    task automatic test_leading_zero();
        bit ok;
        logic [15:0] words [2];
        int lead_from [2];
        logic [3:0] ea;
        words     = '{16'h0050, 16'h0000};
        lead_from = '{2, 1};
        for (int w = 0; w < 2; w++) begin
            cyc(1'b1, words[w]);
            wait_fd(ok);
            total++;
            if (ok !== 1'b1) begin bad++; $display("FAIL lzb_wait_fd: got timeout want frame_done"); end
            cyc(1'b0, 16'h0);
            for (int c = 0; c < 16; c++) begin
                ea = 4'hF;
                if (c % 4 != 0 && !(LZB && (c / 4) >= lead_from[w])) ea[c / 4] = 1'b0;
                total++;
                if (anode_n_o !== ea) begin bad++; $display("FAIL lzb_anode w=%h c=%0d: got %b want %b", words[w], c, anode_n_o, ea); end
                cyc(1'b0, 16'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        cyc(1'b1, 16'h4321);
        wait_fd(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL rm_wait_fd: got timeout want frame_done"); end
        cyc(1'b0, 16'h0);
        repeat (8) cyc(1'b0, 16'h0);
        cyc(1'b1, 16'h9999);
        total++;
        if (digit_idx_o !== 2'd2) begin bad++; $display("FAIL rm_pre_idx: got %0d want 2", digit_idx_o); end
        do_reset(1);
        total++;
        if (digit_idx_o !== 2'd0) begin bad++; $display("FAIL rm_idx: got %0d want 0", digit_idx_o); end
        total++;
        if (anode_n_o !== 4'b1111) begin bad++; $display("FAIL rm_anode: got %b want 1111", anode_n_o); end
        total++;
        if (frame_done_o !== 1'b0) begin bad++; $display("FAIL rm_fd: got %b want 0", frame_done_o); end
        for (int c = 0; c < 40; c++) begin
            total++;
            if (digit_nibble_o !== 4'h0) begin bad++; $display("FAIL rm_nibble c=%0d: got %h want 0", c, digit_nibble_o); end
            total++;
            if (anode_n_o !== m_anode()) begin bad++; $display("FAIL rm_anode_run c=%0d: got %b want %b", c, anode_n_o, m_anode()); end
            cyc(1'b0, 16'h0);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [15:0] mask;
        logic        ld;
        do_reset(1);
        for (int c = 0; c < 800; c++) begin
            total++;
            if (digit_idx_o !== 2'(m_idx())) begin bad++; $display("FAIL rnd_idx c=%0d: got %0d want %0d", c, digit_idx_o, m_idx()); end
            total++;
            if (digit_nibble_o !== m_nibble()) begin bad++; $display("FAIL rnd_nibble c=%0d: got %h want %h", c, digit_nibble_o, m_nibble()); end
            total++;
            if (anode_n_o !== m_anode()) begin bad++; $display("FAIL rnd_anode c=%0d: got %b want %b", c, anode_n_o, m_anode()); end
            total++;
            if (frame_done_o !== m_fd()) begin bad++; $display("FAIL rnd_fd c=%0d: got %b want %b", c, frame_done_o, m_fd()); end
            mask = 16'h0;
            for (int k = 0; k < 4; k++) if ($urandom_range(1, 0) == 1) mask[4*k +: 4] = 4'hF;
            d  = 16'($urandom) & mask;
            ld = ($urandom_range(5, 0) == 0);
            cyc(ld, d);
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_no_tearing();
        test_last_wins();
        test_leading_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
